// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the chorus delay-line SPRAM arbiter.
// The state enum and the SPRAM write-mask constant live here.
package spram_arb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arb_state_e;

  localparam logic [3:0] SPRAM_MASK_ALL = 4'b1111;
  localparam int DEF_ADDR_WIDTH = 14;
  localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/spram_port_arbiter_rd_rr_arbiter.sv
// Round-robin picker for the delayed-tap read requesters. The pointer holds
// the requester with highest priority next time and moves only when a read is taken.
module rd_rr_arbiter #(
  parameter int NUM_RD = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_RD-1:0] elig_i,
  input  logic              take_i,
  output logic [NUM_RD-1:0] grant_o,
  output logic              any_o
);

  localparam int PW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    ptr_d   = ptr_q;
    idx     = '0;
    for (int off = 0; off < NUM_RD; off++) begin
      idx = PW'((int'(ptr_q) + off) % NUM_RD);
      if (!found && elig_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = PW'((int'(idx) + 1) % NUM_RD);
      end
    end
    any_o = found;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (take_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/spram_port_arbiter.sv
// Single-port SPRAM sequencer for the chorus delay line: clears the buffer after
// reset, then serves one write requester (priority) and NUM_RD round-robin readers.
module spram_port_arbiter
  import spram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_RD     = 2,
  parameter int BUF_DEPTH  = 4410,
  parameter int MAX_WAIT   = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wrReq_i,
  input  logic [ADDR_WIDTH-1:0]        wrAddr_i,
  input  logic [DATA_WIDTH-1:0]        wrData_i,
  output logic                         wrAck_o,
  input  logic [NUM_RD-1:0]            rdReq_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rdAddr_i,
  output logic [NUM_RD-1:0]            rdAck_o,
  output logic [DATA_WIDTH-1:0]        rdData_o,
  output logic [NUM_RD-1:0]            rdValid_o,
  output logic                         ready_o,
  output logic [ADDR_WIDTH-1:0]        ramAddr_o,
  output logic [DATA_WIDTH-1:0]        ramData_o,
  output logic                         ramWrEn_o,
  output logic [3:0]                   ramMask_o,
  output logic                         ramCs_o,
  input  logic [DATA_WIDTH-1:0]        ramData_i,
  output logic                         errorLED_o
);

  localparam int NREQ = NUM_RD + 1;
  localparam int CW   = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_CLR = ADDR_WIDTH'(BUF_DEPTH - 1);

  arb_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  ready_q;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic                  wr_ack_q, wr_ack_d;
  logic [NUM_RD-1:0]     rd_ack_q, rd_ack_d;
  logic [NUM_RD-1:0]     rd_tag_q;
  logic [NUM_RD-1:0]     rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  error_q, error_d;

  logic                  run;
  logic                  wr_elig;
  logic [NUM_RD-1:0]     rd_elig;
  logic [NUM_RD-1:0]     rd_grant;
  logic                  rd_any;
  logic [ADDR_WIDTH-1:0] rd_addr_sel;

  // A requester whose ack is currently high may still be holding req; mask it.
  assign run     = (state_q == RUN);
  assign wr_elig = run & wrReq_i & ~wr_ack_q;
  assign rd_elig = rdReq_i & ~rd_ack_q & {NUM_RD{run}};

  rd_rr_arbiter #(
    .NUM_RD (NUM_RD)
  ) u_rd_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .elig_i  (rd_elig),
    .take_i  (~wr_elig),
    .grant_o (rd_grant),
    .any_o   (rd_any)
  );

  always_comb begin
    rd_addr_sel = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_grant[k]) rd_addr_sel = rdAddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ram_cs_d   = 1'b0;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = '0;
    case (state_q)
      CLEAR: begin
        ram_cs_d   = 1'b1;
        ram_we_d   = 1'b1;
        ram_addr_d = clr_addr_q;
        ram_data_d = '0;
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_CLR) state_d = RUN;
      end
      RUN: begin
        if (wr_elig) begin
          ram_cs_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = wrAddr_i;
          ram_data_d = wrData_i;
          wr_ack_d   = 1'b1;
        end else if (rd_any) begin
          ram_cs_d   = 1'b1;
          ram_addr_d = rd_addr_sel;
          rd_ack_d   = rd_grant;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Starvation watch: one wait counter per requester, write at index 0.
  logic [NREQ-1:0] req_all;
  logic [NREQ-1:0] ack_all;
  logic [NREQ-1:0] hit;

  assign req_all = {rdReq_i, wrReq_i};
  assign ack_all = {rd_ack_q, wr_ack_q};

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_wait
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (!req_all[gi] || ack_all[gi]) begin
        cnt_d = '0;
      end else if (run && (cnt_q != CW'(MAX_WAIT))) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign hit[gi] = (cnt_d == CW'(MAX_WAIT));
  end

  assign error_d = error_q | (|hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= '0;
      rd_tag_q   <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= run;
      ram_cs_q   <= ram_cs_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      // SPRAM returns data the cycle after the read is issued; capture it then.
      rd_tag_q   <= rd_ack_q;
      rd_valid_q <= rd_tag_q;
      if (|rd_tag_q) rd_data_q <= ramData_i;
      error_q    <= error_d;
    end
  end

  assign wrAck_o    = wr_ack_q;
  assign rdAck_o    = rd_ack_q;
  assign rdData_o   = rd_data_q;
  assign rdValid_o  = rd_valid_q;
  assign ready_o    = ready_q;
  assign ramAddr_o  = ram_addr_q;
  assign ramData_o  = ram_data_q;
  assign ramWrEn_o  = ram_we_q;
  assign ramMask_o  = SPRAM_MASK_ALL;
  assign ramCs_o    = ram_cs_q;
  assign errorLED_o = error_q;

endmodule

// File: tb/tb_spram_port_arbiter.sv
// Directed bench for spram_port_arbiter with a behavioural SPRAM attached
// (registered read, one cycle latency), small BUF_DEPTH and MAX_WAIT.
module tb_spram_port_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int NR = 2;
  localparam int BD = 8;
  localparam int MW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wrReq;
  logic [AW-1:0]    wrAddr;
  logic [DW-1:0]    wrData;
  logic             wrAck;
  logic [NR-1:0]    rdReq;
  logic [NR*AW-1:0] rdAddr;
  logic [NR-1:0]    rdAck;
  logic [DW-1:0]    rdData;
  logic [NR-1:0]    rdValid;
  logic             ready;
  logic [AW-1:0]    ramAddr;
  logic [DW-1:0]    ramDout;
  logic             ramWrEn;
  logic [3:0]       ramMask;
  logic             ramCs;
  logic [DW-1:0]    ramDin;
  logic             errorLED;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spram_port_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .BUF_DEPTH  (BD),
    .MAX_WAIT   (MW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wrReq_i    (wrReq),
    .wrAddr_i   (wrAddr),
    .wrData_i   (wrData),
    .wrAck_o    (wrAck),
    .rdReq_i    (rdReq),
    .rdAddr_i   (rdAddr),
    .rdAck_o    (rdAck),
    .rdData_o   (rdData),
    .rdValid_o  (rdValid),
    .ready_o    (ready),
    .ramAddr_o  (ramAddr),
    .ramData_o  (ramDout),
    .ramWrEn_o  (ramWrEn),
    .ramMask_o  (ramMask),
    .ramCs_o    (ramCs),
    .ramData_i  (ramDin),
    .errorLED_o (errorLED)
  );

  // Behavioural SPRAM; preloaded with a non-zero pattern so the clear is visible.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ramCs) begin
      if (ramWrEn) mem[ramAddr] <= ramDout;
      else         ramDin <= mem[ramAddr];
    end
  end

  logic [2:0] pri_exp  [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
  logic [2:0] pri2_exp [3] = '{3'b010, 3'b100, 3'b000};
  logic [1:0] alt_pat  [3] = '{2'b01, 2'b10, 2'b00};
  logic [2:0] stv_exp  [4] = '{3'b001, 3'b010, 3'b001, 3'b100};
  logic       stv_err  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    logic [40:0] got_c, exp_c;
    rst = 1'b1; wrReq = 1'b0; wrAddr = '0; wrData = '0; rdReq = '0; rdAddr = '0;
    repeat (3) tick();
    got = {ready, ramCs, ramWrEn, wrAck, rdAck, rdValid, errorLED};
    n_cmp++;
    if (got !== 10'b0 || ramMask !== 4'hF) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b mask %h, want 0 mask f", got, ramMask);
    end
    rst = 1'b0;
    for (int c = 0; c < BD; c++) begin
      tick();
      got_c = {ramCs, ramWrEn, ramAddr, ramDout, wrAck, rdAck, ready, 4'b0};
      exp_c = {1'b1, 1'b1, AW'(c), 16'h0000, 1'b0, 2'b00, 1'b0, 4'b0};
      n_cmp++;
      if (got_c !== exp_c) begin
        n_bad++;
        $display("FAIL clear_cycle%0d: got %h want %h", c, got_c, exp_c);
      end
    end
    tick();
    n_cmp++;
    if ({ready, ramCs} !== 2'b10) begin
      n_bad++;
      $display("FAIL ready_rise: got ready/cs %b want 10", {ready, ramCs});
    end
    $display("clear sequence done, ready=%0b", ready);
  endtask

  task automatic test_write_read();
    logic [AW-1:0] addr_t [2] = '{14'd5, 14'd3};
    logic [DW-1:0] data_t [2] = '{16'h1234, 16'h0000};
    logic [NR-1:0] oh;
    wrReq = 1'b1; wrAddr = 14'd5; wrData = 16'h1234;
    tick();
    n_cmp++;
    if ({wrAck, rdAck, ramCs, ramWrEn, ramAddr, ramDout} !== {1'b1, 2'b00, 1'b1, 1'b1, 14'd5, 16'h1234}) begin
      n_bad++;
      $display("FAIL write_issue: ack %b/%b cs %b we %b addr %0d data %h want 1/00 1 1 5 1234",
               wrAck, rdAck, ramCs, ramWrEn, ramAddr, ramDout);
    end
    $display("write addr 5 data 1234 acked=%0b", wrAck);
    wrReq = 1'b0;
    for (int k = 0; k < NR; k++) begin
      oh = NR'(1) << k;
      rdReq[k] = 1'b1;
      rdAddr[k*AW +: AW] = addr_t[k];
      tick();
      n_cmp++;
      if ({rdAck, wrAck, ramCs, ramWrEn, ramAddr} !== {oh, 1'b0, 1'b1, 1'b0, addr_t[k]}) begin
        n_bad++;
        $display("FAIL read%0d_issue: ack %b cs %b we %b addr %0d want %b 1 0 %0d",
                 k, rdAck, ramCs, ramWrEn, ramAddr, oh, addr_t[k]);
      end
      rdReq[k] = 1'b0;
      tick();
      n_cmp++;
      if (rdValid !== 2'b00) begin
        n_bad++;
        $display("FAIL read%0d_early_valid: got %b want 00", k, rdValid);
      end
      tick();
      n_cmp++;
      if ({rdValid, rdData} !== {oh, data_t[k]}) begin
        n_bad++;
        $display("FAIL read%0d_data: valid %b data %h want %b %h", k, rdValid, rdData, oh, data_t[k]);
      end
      $display("read%0d addr %0d data %h valid %b", k, addr_t[k], rdData, rdValid);
      tick();
      n_cmp++;
      if ({rdValid, rdData} !== {2'b00, data_t[k]}) begin
        n_bad++;
        $display("FAIL read%0d_hold: valid %b data %h want 00 %h", k, rdValid, rdData, data_t[k]);
      end
    end
  endtask

  task automatic test_priority();
    logic [2:0] got;
    wrReq = 1'b1; wrAddr = 14'd7; wrData = 16'hBEEF;
    rdReq = 2'b11; rdAddr = {14'd3, 14'd5};
    for (int i = 0; i < 4; i++) begin
      tick();
      got = {rdAck, wrAck};
      n_cmp++;
      if (got !== pri_exp[i]) begin
        n_bad++;
        $display("FAIL priority_order%0d: got %b want %b", i, got, pri_exp[i]);
      end
      $display("priority cycle %0d acks rd/wr %b", i, got);
      if (wrAck) wrReq = 1'b0;
      rdReq = rdReq & ~rdAck;
    end
    rdReq = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {rdAck, wrAck};
      n_cmp++;
      if (got !== pri2_exp[i]) begin
        n_bad++;
        $display("FAIL rr_resume%0d: got %b want %b", i, got, pri2_exp[i]);
      end
      rdReq = rdReq & ~rdAck;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ack_prev = 2'b00;
    logic [1:0] ack;
    rdReq = 2'b11;
    for (int i = 0; i < 9; i++) begin
      tick();
      ack = rdAck;
      n_cmp++;
      if ({ack, wrAck} !== {alt_pat[i%3], 1'b0}) begin
        n_bad++;
        $display("FAIL alternate%0d: got %b want %b", i, {ack, wrAck}, {alt_pat[i%3], 1'b0});
      end
      rdReq = ~ack_prev;
      ack_prev = ack;
    end
    rdReq = 2'b00;
    repeat (2) tick();
    n_cmp++;
    if (errorLED !== 1'b0) begin
      n_bad++;
      $display("FAIL alternate_no_error: got %b want 0", errorLED);
    end
  endtask

  task automatic test_starvation();
    logic [2:0] got;
    wrReq = 1'b1; wrAddr = 14'd2; wrData = 16'h5555;
    rdReq = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      got = {rdAck, wrAck};
      n_cmp++;
      if ({got, errorLED} !== {stv_exp[i], stv_err[i]}) begin
        n_bad++;
        $display("FAIL starve%0d: acks %b err %b want %b %b", i, got, errorLED, stv_exp[i], stv_err[i]);
      end
    end
    wrReq = 1'b0; rdReq = 2'b00;
    repeat (3) tick();
    n_cmp++;
    if (errorLED !== 1'b1) begin
      n_bad++;
      $display("FAIL starve_sticky: got %b want 1", errorLED);
    end
    $display("starvation flag %0b", errorLED);
  endtask

  task automatic test_reset_midread();
    rdReq = 2'b01; rdAddr[AW-1:0] = 14'd5;
    tick();
    n_cmp++;
    if (rdAck !== 2'b01) begin
      n_bad++;
      $display("FAIL midreset_ack: got %b want 01", rdAck);
    end
    rdReq = 2'b00;
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({ready, rdValid, errorLED, ramCs} !== 5'b0) begin
      n_bad++;
      $display("FAIL midreset_flush: ready/valid/err/cs %b want 00000", {ready, rdValid, errorLED, ramCs});
    end
    rst = 1'b0;
    for (int c = 0; c < BD; c++) begin
      tick();
      n_cmp++;
      if ({ramCs, ramWrEn, ramAddr, rdValid, ready} !== {1'b1, 1'b1, AW'(c), 2'b00, 1'b0}) begin
        n_bad++;
        $display("FAIL reclear%0d: cs %b we %b addr %0d valid %b ready %b want 1 1 %0d 00 0",
                 c, ramCs, ramWrEn, ramAddr, rdValid, ready, c);
      end
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reclear_ready: got %b want 1", ready);
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = 16'hDEAD;
    ramDin = '0;
    test_reset();
    test_write_read();
    test_priority();
    test_back_to_back();
    test_starvation();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
